// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 single-precision multiplier: shift-add mantissa product,
// one-cycle normalise/round, result held until the consumer takes it.
module fp_mul_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int N  = 24 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [47:0]           ma_q, ma_d;
  logic [23:0]           mb_q, mb_d;
  logic [47:0]           acc_q, acc_d;
  logic signed [9:0]     exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic                  spec_q, spec_d;
  logic [31:0]           spec_res_q, spec_res_d;
  logic [31:0]           out_q, out_d;

  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sign_in, is_spec, accept;
  logic [31:0] spec_res;

  assign ea      = in_a[30:23];
  assign eb      = in_b[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (in_a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (in_b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (in_a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (in_b[22:0] != 23'd0);
  assign sign_in = in_a[31] ^ in_b[31];
  assign is_spec = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign accept  = in_valid & in_ready_q;

  always_comb begin
    spec_res = {sign_in, 31'd0};
    if (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf))
      spec_res = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      spec_res = {sign_in, 8'hFF, 23'd0};
  end

  // Normalise a [1,4) product, round to nearest even, and clamp to inf/zero.
  function automatic logic [31:0] round_pack(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [47:0] p);
    logic [22:0]        m;
    logic               g, st;
    logic [23:0]        mr;
    logic signed [10:0] ef;
    ef = {e[9], e};
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      ef = ef + 11'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    if (mr[23]) ef = ef + 11'sd1;
    if (ef >= 11'sd255)     round_pack = {s, 8'hFF, 23'd0};
    else if (ef <= 11'sd0)  round_pack = {s, 31'd0};
    else                    round_pack = {s, ef[7:0], mr[22:0]};
  endfunction

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // ITER runs N+1 cycles; the last adds a zero digit and fixes latency at N+2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_spec ? NORM : ITER;
      ITER:    if (cnt_q == CW'(N)) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == IDLE);
    out_valid  = (state_q == DONE);
  end

  assign in_ready = in_ready_q;
  assign out      = out_q;

  always_comb begin
    ma_d       = ma_q;
    mb_d       = mb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    out_d      = out_q;
    case (state_q)
      IDLE: if (accept) begin
        ma_d       = {24'd0, 1'b1, in_a[22:0]};
        mb_d       = {1'b1, in_b[22:0]};
        acc_d      = '0;
        cnt_d      = '0;
        exp_d      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        sign_d     = sign_in;
        spec_d     = is_spec;
        spec_res_d = spec_res;
      end
      ITER: begin
        acc_d = acc_q + ma_q * 48'(mb_q[BITS_PER_CYCLE-1:0]);
        ma_d  = ma_q << BITS_PER_CYCLE;
        mb_d  = mb_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CW'(1);
      end
      NORM: out_d = spec_q ? spec_res_q : round_pack(sign_q, exp_q, acc_q);
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      ma_q       <= '0;
      mb_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      out_q      <= '0;
    end else begin
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: two instances (1 and 4 bits per cycle) checked every
// cycle against a transaction-level model, plus directed literal vectors.
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_s, b_s;
  logic [1:0]  in_valid_s, out_ready_s;
  logic [1:0]  in_ready_w, out_valid_w;
  logic [31:0] out_w [2];
  logic        chk_en;

  int checks   = 0;
  int failures = 0;

  localparam int LAT [2] = '{24 / 1 + 2, 24 / 4 + 2};

  always #5 clk = ~clk;

  fp_mul_iter #(.BITS_PER_CYCLE(1)) dut1 (
    .iCLK(clk), .iRESET_N(rst_n), .in_a(a_s), .in_b(b_s),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
    .out(out_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]));

  fp_mul_iter #(.BITS_PER_CYCLE(4)) dut4 (
    .iCLK(clk), .iRESET_N(rst_n), .in_a(a_s), .in_b(b_s),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
    .out(out_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]));

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Exact integer product, then round to nearest even by comparing the
  // discarded remainder against half an ulp.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    longint unsigned p, keep, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh   = p[47] ? 24 : 23;
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    e = ea + eb - 127 + (sh - 23);
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  logic        m_rdy [2];
  logic        m_vld [2];
  logic        m_busy[2];
  int          m_cd  [2];
  logic [31:0] m_out [2];
  logic [31:0] m_pend[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_rdy[k]  <= 1'b0;
        m_vld[k]  <= 1'b0;
        m_busy[k] <= 1'b0;
        m_cd[k]   <= 0;
        m_out[k]  <= 32'd0;
      end else if (m_rdy[k] && in_valid_s[k]) begin
        m_rdy[k]  <= 1'b0;
        m_busy[k] <= 1'b1;
        m_cd[k]   <= is_special(a_s, b_s) ? 1 : LAT[k];
        m_pend[k] <= model_mul(a_s, b_s);
      end else if (m_busy[k] && !m_vld[k]) begin
        if (m_cd[k] == 1) begin
          m_vld[k] <= 1'b1;
          m_out[k] <= m_pend[k];
        end
        m_cd[k] <= m_cd[k] - 1;
      end else if (m_vld[k] && out_ready_s[k]) begin
        m_vld[k]  <= 1'b0;
        m_busy[k] <= 1'b0;
        m_rdy[k]  <= 1'b1;
      end else if (!m_busy[k]) begin
        m_rdy[k] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (in_ready_w[k] !== m_rdy[k]) begin
          failures++;
          $display("FAIL cyc_in_ready[%0d] t=%0t actual=%b required=%b", k, $time, in_ready_w[k], m_rdy[k]);
        end
        checks++;
        if (out_valid_w[k] !== m_vld[k]) begin
          failures++;
          $display("FAIL cyc_out_valid[%0d] t=%0t actual=%b required=%b", k, $time, out_valid_w[k], m_vld[k]);
        end
        checks++;
        if (out_w[k] !== m_out[k]) begin
          failures++;
          $display("FAIL cyc_out[%0d] t=%0t actual=%h required=%h", k, $time, out_w[k], m_out[k]);
        end
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Present operands and return #1 after the accepting edge.
  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b, input string nm);
    int t;
    @(negedge clk);
    a_s = a;
    b_s = b;
    in_valid_s[k] = 1'b1;
    t = 0;
    while (!in_ready_w[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      failures++;
      $display("FAIL %s/accept_timeout actual=in_ready_low required=in_ready_high", nm);
    end
    @(posedge clk);
    #1 in_valid_s[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic use_lit, input logic [31:0] lit,
                        input int lat_exp, input string nm);
    logic [31:0] expv;
    int lat;
    expv = use_lit ? lit : model_mul(a, b);
    if (use_lit) check32({nm, "/model"}, model_mul(a, b), lit);
    start_op(k, a, b, nm);
    lat = 0;
    while (!out_valid_w[k] && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int({nm, "/latency"}, lat, lat_exp);
    check32({nm, "/out"}, out_w[k], expv);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_s  = 2'b00;
    out_ready_s = 2'b11;
    a_s         = 32'd0;
    b_s         = 32'd0;
    chk_en      = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    check_int("rst_in_ready", int'(in_ready_w[0]), 0);
    check_int("rst_out_valid", int'(out_valid_w[0]), 0);
    check32("rst_out", out_w[0], 32'h0000_0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_int("rel_in_ready", int'(in_ready_w[0]), 1);
    check_int("rel_in_ready_b4", int'(in_ready_w[1]), 1);

    run_op(0, 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 26, "basic");
    run_op(0, 32'h3F00_0000, 32'hC080_0000, 1'b1, 32'hC000_0000, 26, "sign");
    run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h4010_0000, 26, "norm47");
    run_op(0, 32'h3F80_0001, 32'h3F80_0001, 1'b1, 32'h3F80_0002, 26, "round");
    run_op(1, 32'h3F80_0001, 32'h3F80_0001, 1'b1, 32'h3F80_0002, 8,  "round_b4");
    run_op(1, 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 8,  "basic_b4");
    run_op(0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b1, 32'h407F_FFFE, 26, "maxmant");
    run_op(0, 32'h7F00_0000, 32'h4000_0000, 1'b1, 32'h7F80_0000, 26, "overflow");
    run_op(0, 32'h0080_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 26, "underflow");
    run_op(0, 32'h0000_0001, 32'h4000_0000, 1'b1, 32'h0000_0000, 1,  "denorm");
    run_op(0, 32'h0000_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1,  "zero_inf");
    run_op(0, 32'hFF80_0000, 32'h4000_0000, 1'b1, 32'hFF80_0000, 1,  "ninf");
    run_op(0, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1,  "nan");
    run_op(0, 32'h8000_0000, 32'h4000_0000, 1'b1, 32'h8000_0000, 1,  "negzero");
    run_op(0, 32'h3F80_0001, 32'h3F40_0000, 1'b0, 32'h0,         26, "tie");
    run_op(1, 32'hC120_0000, 32'h3DCC_CCCD, 1'b0, 32'h0,         8,  "mix_b4");

    // Backpressure: result must hold and new operands must be ignored.
    out_ready_s[0] = 1'b0;
    run_op(0, 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 26, "bp");
    a_s = 32'h3F80_0000;
    b_s = 32'h3F80_0000;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_int("bp_hold_valid", int'(out_valid_w[0]), 1);
      check32("bp_hold_out", out_w[0], 32'h40C0_0000);
      check_int("bp_hold_in_ready", int'(in_ready_w[0]), 0);
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1 check_int("bp_release_in_ready", int'(in_ready_w[0]), 1);
    check_int("bp_release_valid", int'(out_valid_w[0]), 0);

    // Reset during the fifth ITER cycle aborts the operation.
    start_op(0, 32'h4000_0000, 32'h4040_0000, "abort");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 check_int("abort_valid", int'(out_valid_w[0]), 0);
    check32("abort_out", out_w[0], 32'h0000_0000);
    check_int("abort_in_ready", int'(in_ready_w[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_int("abort_rel_in_ready", int'(in_ready_w[0]), 1);
    run_op(0, 32'h4000_0000, 32'h4000_0000, 1'b1, 32'h4080_0000, 26, "post_abort");

    // Reset while a result is held in DONE discards it.
    out_ready_s[1] = 1'b0;
    run_op(1, 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 8, "done_hold_b4");
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_int("done_rst_valid_b4", int'(out_valid_w[1]), 0);
    check32("done_rst_out_b4", out_w[1], 32'h0000_0000);
    rst_n = 1'b1;
    out_ready_s[1] = 1'b1;
    @(posedge clk);
    #1 check_int("done_rst_in_ready_b4", int'(in_ready_w[1]), 1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
